axi_read_port_arbiter: RTL and testbench

Shares the single DDR read-address channel between NUM_REQ read requesters, e.g. display scanout, blitter and host bridge. It feeds the AR input of the pseudo-AXI arbiter that merges AR and AW onto the controller's address channel. The requester index is encoded in the upper bits of the downstream ARID. Returning R beats are routed back to their requester by decoding RID. Each requester has an outstanding-burst cap so that no single requester can monopolise the controller's read queue.

---
 rtl/paxi_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 58 +++++
 rtl/axi_read_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_axi_read_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paxi_pkg.sv
// Shared pseudo-AXI address-channel types and widths, used by the read/write
// port arbiters and the AR/AW merge stage.
package paxi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned LEN_W  = 8;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [1:0]        lock;
  } paxi_ar_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with optional fixed-priority override for
// requester 0. The pointer moves only on an accepted round-robin grant.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  input  logic             prio0_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             prio_hit;

  always_comb begin
    int unsigned j;
    j           = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    prio_hit    = prio0_i && req_i[0];
    if (prio_hit) begin
      gnt_o[0]    = 1'b1;
      gnt_valid_o = 1'b1;
    end else begin
      // Search starts one past the last round-robin winner and wraps.
      for (int unsigned k = 1; k <= N; k++) begin
        j = (32'(ptr_q) + k) % N;
        if (!gnt_valid_o && req_i[j]) begin
          gnt_o[j]    = 1'b1;
          gnt_idx_o   = IDX_W'(j);
          gnt_valid_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && gnt_valid_o && !prio_hit) begin
      ptr_d = gnt_idx_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axi_read_port_arbiter.sv
// Shares the DDR read-address channel among NUM_REQ requesters, tags ARID
// with the requester index, and routes R beats back by decoding RID.
module axi_read_port_arbiter
  import paxi_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned MAX_OUTST = 4,
  parameter bit          PRIO0     = 1'b1,
  parameter int unsigned DATA_W    = 128
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [ID_W*NUM_REQ-1:0]     req_arid,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_araddr,
  input  logic [LEN_W*NUM_REQ-1:0]    req_arlen,
  input  logic [3*NUM_REQ-1:0]        req_arsize,
  input  logic [2*NUM_REQ-1:0]        req_arburst,
  input  logic [NUM_REQ-1:0]          req_arvalid,
  output logic [NUM_REQ-1:0]          req_arready,
  output logic [ID_W*NUM_REQ-1:0]     req_rid,
  output logic [DATA_W*NUM_REQ-1:0]   req_rdata,
  output logic [2*NUM_REQ-1:0]        req_rresp,
  output logic [NUM_REQ-1:0]          req_rlast,
  output logic [NUM_REQ-1:0]          req_rvalid,
  input  logic [NUM_REQ-1:0]          req_rready,
  output logic [ID_W-1:0]             axi_arid,
  output logic [ADDR_W-1:0]           axi_araddr,
  output logic [LEN_W-1:0]            axi_arlen,
  output logic [2:0]                  axi_arsize,
  output logic [1:0]                  axi_arburst,
  output logic [1:0]                  axi_arlock,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [ID_W-1:0]             axi_rid,
  input  logic [DATA_W-1:0]           axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rlast,
  input  logic                        axi_rvalid,
  output logic                        axi_rready,
  output logic                        err_unmapped
);

  localparam int unsigned LOW_W = ID_W - IDX_W;

  paxi_ar_t         ar_q, ar_d;
  logic             arvalid_q, arvalid_d;
  logic [3:0]       outst_q [NUM_REQ];
  logic [3:0]       outst_d [NUM_REQ];
  logic             err_q, err_d;

  logic               slice_free;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic [IDX_W-1:0]   r_idx;
  logic               r_mapped;
  logic               rlast_hs;

  // Gating on resetn keeps req_arready low while reset is held.
  assign slice_free = resetn && (!arvalid_q || axi_arready);

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_arvalid[i] && (outst_q[i] < 4'(MAX_OUTST));
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk         (clk),
    .rst_n       (resetn),
    .req_i       (eligible),
    .advance_i   (slice_free),
    .prio0_i     (PRIO0),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign req_arready = slice_free ? gnt : '0;

  always_comb begin
    ar_d      = ar_q;
    arvalid_d = arvalid_q;
    if (slice_free) begin
      arvalid_d = gnt_valid;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          ar_d.id    = {IDX_W'(i), req_arid[ID_W*i +: LOW_W]};
          ar_d.addr  = req_araddr[ADDR_W*i +: ADDR_W];
          ar_d.len   = req_arlen[LEN_W*i +: LEN_W];
          ar_d.size  = req_arsize[3*i +: 3];
          ar_d.burst = req_arburst[2*i +: 2];
          ar_d.lock  = '0;
        end
      end
    end
  end

  assign axi_arid    = ar_q.id;
  assign axi_araddr  = ar_q.addr;
  assign axi_arlen   = ar_q.len;
  assign axi_arsize  = ar_q.size;
  assign axi_arburst = ar_q.burst;
  assign axi_arlock  = ar_q.lock;
  assign axi_arvalid = arvalid_q;

  assign r_idx    = axi_rid[ID_W-1 -: IDX_W];
  assign r_mapped = 32'(r_idx) < NUM_REQ;
  assign rlast_hs = axi_rvalid && axi_rready && axi_rlast;

  // Unmapped beats fall through with rready=1 so the channel never wedges.
  always_comb begin
    axi_rready = 1'b1;
    req_rvalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_rid[ID_W*i +: ID_W]       = {{IDX_W{1'b0}}, axi_rid[LOW_W-1:0]};
      req_rdata[DATA_W*i +: DATA_W] = axi_rdata;
      req_rresp[2*i +: 2]           = axi_rresp;
      req_rlast[i]                  = axi_rlast;
      if (r_idx == IDX_W'(i)) begin
        req_rvalid[i] = axi_rvalid;
        axi_rready    = req_rready[i];
      end
    end
  end

  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc        = slice_free && gnt[i];
      dec        = rlast_hs && (r_idx == IDX_W'(i)) && (outst_q[i] != '0);
      outst_d[i] = outst_q[i];
      if (inc && !dec) begin
        outst_d[i] = outst_q[i] + 4'd1;
      end else if (dec && !inc) begin
        outst_d[i] = outst_q[i] - 4'd1;
      end
    end
  end

  assign err_d        = err_q || (axi_rvalid && !r_mapped);
  assign err_unmapped = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_q      <= '0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        outst_q[i] <= '0;
      end
    end else begin
      ar_q      <= ar_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        outst_q[i] <= outst_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
    a_no_unmatched_rlast: assert property (@(posedge clk) disable iff (!resetn)
      !(rlast_hs && (r_idx == IDX_W'(g)) && (outst_q[g] == '0)));
  end

endmodule

// File: tb/tb_axi_read_port_arbiter.sv
// Drives two arbiter instances (round-robin and requester-0 priority) with
// directed scenarios and random traffic, checked against a transaction model.
module tb_axi_read_port_arbiter;

  localparam int N    = 3;
  localparam int IW   = 2;
  localparam int MAXO = 4;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic resetn;

  logic [8*N-1:0]  arid    [2];
  logic [32*N-1:0] araddr  [2];
  logic [8*N-1:0]  arlen   [2];
  logic [3*N-1:0]  arsize  [2];
  logic [2*N-1:0]  arburst [2];
  logic [N-1:0]    arvalid [2];
  logic [N-1:0]    arready_o [2];
  logic [8*N-1:0]  rid_o   [2];
  logic [DW*N-1:0] rdata_o [2];
  logic [2*N-1:0]  rresp_o [2];
  logic [N-1:0]    rlast_o [2];
  logic [N-1:0]    rvalid_o [2];
  logic [N-1:0]    rready  [2];
  logic [7:0]      axi_arid_o    [2];
  logic [31:0]     axi_araddr_o  [2];
  logic [7:0]      axi_arlen_o   [2];
  logic [2:0]      axi_arsize_o  [2];
  logic [1:0]      axi_arburst_o [2];
  logic [1:0]      axi_arlock_o  [2];
  logic            axi_arvalid_o [2];
  logic            axi_arready   [2];
  logic [7:0]      axi_rid       [2];
  logic [DW-1:0]   axi_rdata     [2];
  logic [1:0]      axi_rresp     [2];
  logic            axi_rlast     [2];
  logic            axi_rvalid    [2];
  logic            axi_rready_o  [2];
  logic            err_o         [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_read_port_arbiter #(
      .NUM_REQ(N), .IDX_W(IW), .MAX_OUTST(MAXO), .PRIO0(g == 1), .DATA_W(DW)
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .req_arid(arid[g]), .req_araddr(araddr[g]), .req_arlen(arlen[g]),
      .req_arsize(arsize[g]), .req_arburst(arburst[g]),
      .req_arvalid(arvalid[g]), .req_arready(arready_o[g]),
      .req_rid(rid_o[g]), .req_rdata(rdata_o[g]), .req_rresp(rresp_o[g]),
      .req_rlast(rlast_o[g]), .req_rvalid(rvalid_o[g]), .req_rready(rready[g]),
      .axi_arid(axi_arid_o[g]), .axi_araddr(axi_araddr_o[g]), .axi_arlen(axi_arlen_o[g]),
      .axi_arsize(axi_arsize_o[g]), .axi_arburst(axi_arburst_o[g]), .axi_arlock(axi_arlock_o[g]),
      .axi_arvalid(axi_arvalid_o[g]), .axi_arready(axi_arready[g]),
      .axi_rid(axi_rid[g]), .axi_rdata(axi_rdata[g]), .axi_rresp(axi_rresp[g]),
      .axi_rlast(axi_rlast[g]), .axi_rvalid(axi_rvalid[g]), .axi_rready(axi_rready_o[g]),
      .err_unmapped(err_o[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: pending slice content, per-requester counts,
  // last round-robin winner, sticky error.
  bit          m_sv    [2];
  logic [7:0]  m_id    [2];
  logic [31:0] m_addr  [2];
  logic [7:0]  m_len   [2];
  logic [2:0]  m_size  [2];
  logic [1:0]  m_burst [2];
  int          m_outst [2][N];
  int          m_ptr   [2];
  bit          m_err   [2];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sv[d] = 0; m_id[d] = '0; m_addr[d] = '0; m_len[d] = '0;
      m_size[d] = '0; m_burst[d] = '0; m_ptr[d] = N - 1; m_err[d] = 0;
      for (int i = 0; i < N; i++) m_outst[d][i] = 0;
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      arid[d] = '0; araddr[d] = '0; arlen[d] = '0; arsize[d] = '0; arburst[d] = '0;
      arvalid[d] = '0; rready[d] = '1; axi_arready[d] = 1'b1;
      axi_rid[d] = '0; axi_rdata[d] = '0; axi_rresp[d] = '0;
      axi_rlast[d] = 1'b0; axi_rvalid[d] = 1'b0;
    end
  endtask

  task automatic eval_dut(input int d);
    bit free, rr, dec;
    int win, idx;
    logic [N-1:0] exp_rdy, exp_rv;
    logic exp_rr;
    free = !m_sv[d] || axi_arready[d];
    win = -1; rr = 0;
    if (free) begin
      if (d == 1 && arvalid[d][0] && m_outst[d][0] < MAXO) win = 0;
      else begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr[d] + k) % N;
          if (win < 0 && arvalid[d][j] && m_outst[d][j] < MAXO) begin win = j; rr = 1; end
        end
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check_eq("req_arready", arready_o[d], exp_rdy);
    check_eq("axi_arvalid", axi_arvalid_o[d], m_sv[d]);
    check_eq("axi_arlock", axi_arlock_o[d], 2'b00);
    if (m_sv[d]) begin
      check_eq("axi_arid", axi_arid_o[d], m_id[d]);
      check_eq("axi_araddr", axi_araddr_o[d], m_addr[d]);
      check_eq("axi_arlen", axi_arlen_o[d], m_len[d]);
      check_eq("axi_arsize", axi_arsize_o[d], m_size[d]);
      check_eq("axi_arburst", axi_arburst_o[d], m_burst[d]);
    end
    idx = int'(axi_rid[d][7:6]);
    exp_rr = 1'b1;
    exp_rv = '0;
    if (idx < N) begin
      exp_rr = rready[d][idx];
      exp_rv[idx] = axi_rvalid[d];
      check_eq("req_rid", rid_o[d][8*idx +: 8], {2'b00, axi_rid[d][5:0]});
      check_eq("req_rdata", rdata_o[d][DW*idx +: DW], axi_rdata[d]);
    end
    check_eq("axi_rready", axi_rready_o[d], exp_rr);
    check_eq("req_rvalid", rvalid_o[d], exp_rv);
    check_eq("err_unmapped", err_o[d], m_err[d]);

    dec = axi_rvalid[d] && idx < N && rready[d][idx] && axi_rlast[d] && m_outst[d][idx] > 0;
    if (dec) m_outst[d][idx]--;
    if (free) begin
      m_sv[d] = (win >= 0);
      if (win >= 0) begin
        m_id[d]    = {2'(win), arid[d][8*win +: 6]};
        m_addr[d]  = araddr[d][32*win +: 32];
        m_len[d]   = arlen[d][8*win +: 8];
        m_size[d]  = arsize[d][3*win +: 3];
        m_burst[d] = arburst[d][2*win +: 2];
        m_outst[d][win]++;
        if (rr) m_ptr[d] = win;
      end
    end
    if (axi_rvalid[d] && idx >= N) m_err[d] = 1;
  endtask

  task automatic eval();
    #1;
    for (int d = 0; d < 2; d++) eval_dut(d);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    for (int d = 0; d < 2; d++) arvalid[d] = '1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_arvalid", axi_arvalid_o[d], 1'b0);
      check_eq("rst_arready", arready_o[d], '0);
      check_eq("rst_araddr", axi_araddr_o[d], '0);
      check_eq("rst_arid", axi_arid_o[d], '0);
      check_eq("rst_err", err_o[d], 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int d = 0; d < 2; d++) arvalid[d] = '0;
  endtask

  task automatic drive_random(input int d);
    int idx;
    arvalid[d] = N'($urandom);
    for (int i = 0; i < N; i++) begin
      arid[d][8*i +: 8]    = 8'($urandom);
      araddr[d][32*i +: 32] = $urandom;
      arlen[d][8*i +: 8]   = 8'($urandom);
      arsize[d][3*i +: 3]  = 3'($urandom);
      arburst[d][2*i +: 2] = 2'($urandom);
    end
    axi_arready[d] = ($urandom_range(0, 3) != 0);
    rready[d]      = N'($urandom);
    axi_rvalid[d]  = $urandom_range(0, 1) == 1;
    idx            = ($urandom_range(0, 49) == 0) ? 3 : $urandom_range(0, N - 1);
    axi_rid[d]     = {2'(idx), 6'($urandom)};
    axi_rdata[d]   = DW'($urandom);
    axi_rresp[d]   = 2'($urandom);
    axi_rlast[d]   = $urandom_range(0, 1) == 1;
    if (idx < N && m_outst[d][idx] == 0) axi_rlast[d] = 1'b0;
  endtask

  // Test 4 schedule: expected req_arready[1] and rlast injection per cycle.
  bit t4_gnt [11] = '{1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 0};
  bit t4_rl  [11] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};

  initial begin
    do_reset();

    // Single request from requester 0.
    for (int d = 0; d < 2; d++) begin
      arid[d][7:0] = 8'h05; araddr[d][31:0] = 32'h1000; arlen[d][7:0] = 8'h07;
      arvalid[d] = 3'b001;
    end
    eval();
    for (int d = 0; d < 2; d++) check_eq("t1_grant", arready_o[d], 3'b001);
    tick();
    for (int d = 0; d < 2; d++) arvalid[d] = '0;
    eval();
    for (int d = 0; d < 2; d++) begin
      check_eq("t1_arvalid", axi_arvalid_o[d], 1'b1);
      check_eq("t1_arid", axi_arid_o[d], 8'h05);
      check_eq("t1_araddr", axi_araddr_o[d], 32'h1000);
      check_eq("t1_single_pulse", arready_o[d], 3'b000);
    end
    tick();

    // All requesters valid: round-robin order on instance 0.
    do_reset();
    for (int d = 0; d < 2; d++) arvalid[d] = '1;
    for (int c = 0; c < 6; c++) begin
      eval();
      check_eq("t2_rr_order", arready_o[0], 64'(1) << (c % 3));
      tick();
    end

    // Requester 0 valid every third cycle: priority on instance 1.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      for (int d = 0; d < 2; d++) arvalid[d] = {2'b11, (c % 3) == 0};
      eval();
      check_eq("t3_prio_order", arready_o[1], 64'(1) << (c % 3));
      tick();
    end

    // Outstanding cap on requester 1, release by rlast, simultaneous grant+rlast.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      for (int d = 0; d < 2; d++) begin
        arvalid[d] = 3'b010;
        axi_rvalid[d] = t4_rl[c];
        axi_rlast[d]  = t4_rl[c];
        axi_rid[d]    = 8'h40 | 8'(c);
      end
      eval();
      for (int d = 0; d < 2; d++) check_eq("t4_cap", arready_o[d][1], t4_gnt[c]);
      tick();
    end

    // Back-pressure: slice holds while axi_arready is low.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      araddr[d] = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000};
      arvalid[d] = 3'b101;
      axi_arready[d] = 1'b0;
    end
    eval();
    tick();
    for (int d = 0; d < 2; d++) araddr[d][31:0] = 32'h0000_5000;
    for (int c = 0; c < 5; c++) begin
      eval();
      for (int d = 0; d < 2; d++) begin
        check_eq("t5_hold_valid", axi_arvalid_o[d], 1'b1);
        check_eq("t5_hold_addr", axi_araddr_o[d], 32'h2000);
        check_eq("t5_no_grant", arready_o[d], 3'b000);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) axi_arready[d] = 1'b1;
    eval();
    check_eq("t5_rr_next", arready_o[0], 3'b100);
    check_eq("t5_prio_next", arready_o[1], 3'b001);
    tick();

    // Unmapped RID index and R back-pressure.
    do_reset();
    for (int d = 0; d < 2; d++) begin
      axi_rvalid[d] = 1'b1; axi_rid[d] = 8'hC0; rready[d] = '0;
    end
    eval();
    for (int d = 0; d < 2; d++) check_eq("t6_unmapped_rready", axi_rready_o[d], 1'b1);
    tick();
    for (int d = 0; d < 2; d++) axi_rvalid[d] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      eval();
      for (int d = 0; d < 2; d++) check_eq("t6_err_sticky", err_o[d], 1'b1);
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      axi_rvalid[d] = 1'b1; axi_rid[d] = 8'h80; rready[d] = 3'b011;
    end
    eval();
    for (int d = 0; d < 2; d++) begin
      check_eq("t6_rready_bp", axi_rready_o[d], 1'b0);
      check_eq("t6_rvalid_route", rvalid_o[d], 3'b100);
    end
    tick();

    // Random traffic on both instances.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) drive_random(d);
      eval();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
